fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage, 16-bit, 16-register CPU.
- Owns the PC and drives the instruction-memory address.
- Presents the fetched instruction to decode, where the hazard detection unit reads its opcode and register fields.
- Consumes the hazard unit's stall and the EX stage's branch redirect; handles HLT.

Parameters:
- PC_W, 16, PC and instruction-memory address width (word addressed).
- INSTR_W, 16, instruction width; opcode is bits [15:12].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  from hazard detection unit; hold PC and IF/ID.
- redirect  in  1  from EX; branch/jump taken, flush wrong path.
- redirect_pc  in  PC_W  target PC for redirect.
- imem_addr  out  PC_W  instruction-memory address; equals PC (combinational from register).
- imem_data  in  INSTR_W  instruction at imem_addr, combinational read.
- id_instr  out  INSTR_W  IF/ID instruction register.
- id_pc1  out  PC_W  IF/ID PC+1 of that instruction.
- id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch has stopped on HLT.

Behaviour:
- Reset (asynchronous):
  - PC=RESET_PC, id_instr=NOP_INSTR (16'h0000), id_pc1=0, id_valid=0, state=RUN, halted=0.
- States:
  - RUN: fetching.
  - HALTED: PC frozen; halted=1.
- Per-cycle priority: redirect > stall > normal.
- redirect=1, any state:
  - PC<=redirect_pc.
  - IF/ID <= bubble (id_instr=NOP_INSTR, id_valid=0).
  - state<=RUN.
  - stall that cycle is ignored, since the ID instruction is wrong-path.
- stall=1, no redirect: PC and all IF/ID registers hold their values.
- Normal in RUN:
  - id_instr<=imem_data, id_pc1<=PC+1 (mod 2^PC_W, wraps), id_valid<=1.
  - If imem_data[15:12]==OPCODE_HLT: PC holds, state<=HALTED. Otherwise PC<=PC+1.
- Normal in HALTED: PC holds; IF/ID <= bubble every cycle. The HLT itself has already been passed downstream.
- Latency: an instruction at address A appears on id_instr one cycle after PC==A, absent stall.
- Redirect restarts fetch at redirect_pc one cycle later (fetch of target), with the target appearing on id_instr two cycles after redirect.
- Stall lasting N cycles delays everything by exactly N cycles; no instruction is lost or duplicated.
- PC=2^PC_W-1 with normal advance: PC wraps to 0 and id_pc1=0.
- Reset asserted mid-stall or mid-HALTED returns immediately to reset values.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0.
  - stall_cnt increments on every cycle with stall=1 and redirect=0.
  - flush_cnt increments on every cycle with redirect=1.
  - Both saturate at 32'hFFFF_FFFF.
- When undefined: the ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds: OPCODE_HLT=4'd15, NOP_INSTR=16'h0000, opcode field position constants, the fetch state encoding (RUN=1'b0, HALTED=1'b1).
- The hazard detection unit and decoder reuse the opcode constants.
- One natural sub-module, sat_counter: width-parameterised, saturating, reset to 0. Instantiated twice under FETCH_PERF_CNT_EN.

Test Plan:
- Reset, then imem returns 16'h1123 at PC 0 and 16'h2456 at PC 1 → cycle 1: id_instr=16'h1123, id_pc1=1, id_valid=1; cycle 2: id_instr=16'h2456, id_pc1=2.
- stall=1 for 2 cycles while id_instr=16'h8120 → PC and id_instr unchanged for both cycles; the next instruction follows with no gap and no duplicate.
- redirect=1 with redirect_pc=16'h0040, stall=1 in the same cycle → next cycle: PC=16'h0040, id_valid=0, id_instr=16'h0000; following cycle: id_instr=imem[0x40].
- Fetch 16'hF000 at PC 5 → id_instr=16'hF000 and halted=1; PC stays 5; subsequent id_valid=0. Then redirect to 16'h0010 → halted=0 and fetch resumes at 0x10.
- RESET_PC=16'hFFFF → first id_pc1=0 and next PC=0 (wrap).
- FETCH_PERF_CNT_EN defined, 3 stall cycles and 2 redirect cycles (one overlapping a stall) → stall_cnt=2, flush_cnt=2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode field layout, special instructions and fetch state encoding.
package cpu_pkg;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;

  localparam logic [3:0]  OPCODE_HLT = 4'd15;
  localparam logic [15:0] NOP_INSTR  = 16'h0000;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; asynchronous active-high reset to 0.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC, redirect/stall handling and HLT.
// Define FETCH_PERF_CNT_EN to add saturating stall/flush event counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W     = 16,
  parameter int unsigned      INSTR_W  = 16,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc1,
  output logic               id_valid,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  fetch_state_e        r_state, w_state_d;
  logic [PC_W-1:0]     r_pc, w_pc_d;
  logic [INSTR_W-1:0]  r_instr, w_instr_d;
  logic [PC_W-1:0]     r_pc1, w_pc1_d;
  logic                r_valid, w_valid_d;
  logic [PC_W-1:0]     w_pc_inc;
  logic                w_is_hlt;

  assign w_pc_inc = r_pc + 1'b1;
  assign w_is_hlt = (imem_data[OPC_MSB:OPC_LSB] == OPCODE_HLT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StRun;
      r_pc    <= RESET_PC;
      r_instr <= INSTR_W'(NOP_INSTR);
      r_pc1   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_instr <= w_instr_d;
      r_pc1   <= w_pc1_d;
      r_valid <= w_valid_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_instr_d = r_instr;
    w_pc1_d   = r_pc1;
    w_valid_d = r_valid;
    if (redirect) begin
      // Stall is ignored here: whatever ID is stalling on is wrong-path.
      w_pc_d    = redirect_pc;
      w_instr_d = INSTR_W'(NOP_INSTR);
      w_valid_d = 1'b0;
      w_state_d = StRun;
    end else if (stall) begin
      w_state_d = r_state;
    end else if (r_state == StRun) begin
      w_instr_d = imem_data;
      w_pc1_d   = w_pc_inc;
      w_valid_d = 1'b1;
      if (w_is_hlt) begin
        w_state_d = StHalted;
      end else begin
        w_pc_d = w_pc_inc;
      end
    end else begin
      w_instr_d = INSTR_W'(NOP_INSTR);
      w_valid_d = 1'b0;
    end
  end

  assign imem_addr = r_pc;
  assign id_instr  = r_instr;
  assign id_pc1    = r_pc1;
  assign id_valid  = r_valid;
  assign halted    = (r_state == StHalted);

`ifdef FETCH_PERF_CNT_EN
  logic w_stall_evt;

  assign w_stall_evt = stall & ~redirect;

  sat_counter #(
    .W (32)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_stall_evt),
    .o_count (stall_cnt)
  );

  sat_counter #(
    .W (32)
  ) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (redirect),
    .o_count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; second instance covers RESET_PC wrap.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] id_instr;
  logic [15:0] id_pc1;
  logic        id_valid;
  logic        halted;

  logic [15:0] w_addr;
  logic [15:0] w_data;
  logic [15:0] w_instr;
  logic [15:0] w_pc1;
  logic        w_valid;
  logic        w_halted;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] w_stall_cnt;
  logic [31:0] w_flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] imem_f(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1123;
      16'h0001: return 16'h2456;
      16'h0002: return 16'h8120;
      16'h0003: return 16'h3001;
      16'h0004: return 16'h4002;
      16'h0005: return 16'hF000;
      16'h0010: return 16'h5555;
      16'h0011: return 16'h6666;
      16'h0040: return 16'h7777;
      16'h0041: return 16'h9999;
      default:  return {4'h1, a[11:0]};
    endcase
  endfunction

  assign imem_data = imem_f(imem_addr);
  assign w_data    = imem_f(w_addr);

  fetch_stage #(
    .PC_W     (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .id_instr    (id_instr),
    .id_pc1      (id_pc1),
    .id_valid    (id_valid),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  fetch_stage #(
    .PC_W     (16),
    .INSTR_W  (16),
    .RESET_PC (16'hFFFF)
  ) u_wrap (
    .clk         (clk),
    .rst         (rst),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (16'h0000),
    .imem_addr   (w_addr),
    .imem_data   (w_data),
    .id_instr    (w_instr),
    .id_pc1      (w_pc1),
    .id_valid    (w_valid),
    .halted      (w_halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt   (w_stall_cnt),
    .flush_cnt   (w_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full IF/ID view plus PC and halted in one go.
  task automatic expect_if(input string tag, input logic [15:0] pc, input logic [15:0] instr,
                           input logic [15:0] pc1, input logic valid, input logic hlt);
    check({tag, ".pc"},     32'(imem_addr), 32'(pc));
    check({tag, ".instr"},  32'(id_instr),  32'(instr));
    check({tag, ".pc1"},    32'(id_pc1),    32'(pc1));
    check({tag, ".valid"},  32'(id_valid),  32'(valid));
    check({tag, ".halted"}, 32'(halted),    32'(hlt));
  endtask

  initial begin
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    #2 rst = 1'b1;
    #1;
    expect_if("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("wrap.reset_pc", 32'(w_addr), 32'h0000_FFFF);
    tick();
    tick();
    rst = 1'b0;

    tick();
    expect_if("fetch0", 16'h0001, 16'h1123, 16'h0001, 1'b1, 1'b0);
    check("wrap.pc1", 32'(w_pc1), 32'h0000_0000);
    check("wrap.pc",  32'(w_addr), 32'h0000_0000);
    check("wrap.instr", 32'(w_instr), 32'h0000_1FFF);
    tick();
    expect_if("fetch1", 16'h0002, 16'h2456, 16'h0002, 1'b1, 1'b0);
    tick();
    expect_if("fetch2", 16'h0003, 16'h8120, 16'h0003, 1'b1, 1'b0);

    stall = 1'b1;
    tick();
    expect_if("stall_a", 16'h0003, 16'h8120, 16'h0003, 1'b1, 1'b0);
    tick();
    expect_if("stall_b", 16'h0003, 16'h8120, 16'h0003, 1'b1, 1'b0);
    stall = 1'b0;
    tick();
    expect_if("post_stall", 16'h0004, 16'h3001, 16'h0004, 1'b1, 1'b0);
    tick();
    expect_if("fetch4", 16'h0005, 16'h4002, 16'h0005, 1'b1, 1'b0);

    tick();
    expect_if("hlt", 16'h0005, 16'hF000, 16'h0006, 1'b1, 1'b1);
    tick();
    expect_if("halted_a", 16'h0005, 16'h0000, 16'h0006, 1'b0, 1'b1);
    tick();
    expect_if("halted_b", 16'h0005, 16'h0000, 16'h0006, 1'b0, 1'b1);

    redirect    = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    expect_if("unhalt", 16'h0010, 16'h0000, 16'h0006, 1'b0, 1'b0);
    redirect = 1'b0;
    tick();
    expect_if("resume", 16'h0011, 16'h5555, 16'h0011, 1'b1, 1'b0);

    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    stall       = 1'b1;
    tick();
    expect_if("redir_stall", 16'h0040, 16'h0000, 16'h0011, 1'b0, 1'b0);
    redirect = 1'b0;
    stall    = 1'b0;
    tick();
    expect_if("target", 16'h0041, 16'h7777, 16'h0041, 1'b1, 1'b0);

`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", stall_cnt, 32'd2);
    check("flush_cnt", flush_cnt, 32'd2);
`endif

    stall = 1'b1;
    tick();
    expect_if("stall_c", 16'h0041, 16'h7777, 16'h0041, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_if("mid_stall_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt_rst", stall_cnt, 32'd0);
    check("flush_cnt_rst", flush_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
